// File: rtl/tc_temp_filter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tc_temp_filter_if : sample-in / filtered-result-out bundle for the filter  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface tc_temp_filter_if #(
  parameter int TEMP_W = 20
);
  logic              i_clr;
  logic [1:0]        i_mode;
  logic [TEMP_W-1:0] i_temp;
  logic              i_stb;
  logic [TEMP_W-1:0] o_temp;
  logic              o_stb;
  logic              o_valid;
  logic [TEMP_W-1:0] o_min;
  logic [TEMP_W-1:0] o_max;

  modport master (
    output i_clr, i_mode, i_temp, i_stb,
    input  o_temp, o_stb, o_valid, o_min, o_max
  );

  modport slave (
    input  i_clr, i_mode, i_temp, i_stb,
    output o_temp, o_stb, o_valid, o_min, o_max
  );
endinterface
`default_nettype wire

// File: rtl/tc_temp_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tc_temp_filter : bypass / block-average / EMA filter with min/max tracking |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tc_temp_filter #(
  parameter int TEMP_W    = 20,
  parameter int LOG2_N    = 3,
  parameter int EMA_SHIFT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  tc_temp_filter_if.slave   bus
);

  localparam int ACC_W = TEMP_W + LOG2_N;

  typedef enum logic [0:0] {
    EMA_EMPTY = 1'b0,
    EMA_RUN   = 1'b1
  } ema_state_e;

  logic [1:0]        mode_q, mode_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [LOG2_N-1:0] cnt_q, cnt_d;
  ema_state_e        ema_state_q, ema_state_d;
  logic [TEMP_W-1:0] ema_y_q, ema_y_d;
  logic [TEMP_W-1:0] o_temp_q, o_temp_d;
  logic              o_stb_q, o_stb_d;
  logic              o_valid_q, o_valid_d;
  logic [TEMP_W-1:0] o_min_q, o_min_d;
  logic [TEMP_W-1:0] o_max_q, o_max_d;

  logic              restart;
  logic [ACC_W-1:0]  blk_sum;
  logic [TEMP_W-1:0] blk_avg;
  logic signed [TEMP_W:0] ema_diff;
  logic [TEMP_W-1:0] ema_step;
  logic [TEMP_W-1:0] ema_next;

  assign restart = (bus.i_mode != mode_q);
  assign blk_sum = acc_q + ACC_W'(bus.i_temp);
  assign blk_avg = blk_sum[ACC_W-1:LOG2_N];

  // The true update always lands between y and the sample, so modulo-2^TEMP_W
  // addition of the sign-extended step yields the exact result.
  assign ema_diff = $signed({1'b0, bus.i_temp}) - $signed({1'b0, ema_y_q});
  assign ema_step = TEMP_W'(ema_diff >>> EMA_SHIFT);
  assign ema_next = ema_y_q + ema_step;

  always_comb begin
    mode_d      = bus.i_mode;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ema_state_d = ema_state_q;
    ema_y_d     = ema_y_q;
    o_temp_d    = o_temp_q;
    o_stb_d     = 1'b0;
    o_valid_d   = o_valid_q;
    o_min_d     = o_min_q;
    o_max_d     = o_max_q;

    if (bus.i_clr) begin
      acc_d       = '0;
      cnt_d       = '0;
      ema_state_d = EMA_EMPTY;
      o_temp_d    = '0;
      o_valid_d   = 1'b0;
      o_min_d     = '1;
      o_max_d     = '0;
    end else if (restart) begin
      acc_d       = '0;
      cnt_d       = '0;
      ema_state_d = EMA_EMPTY;
    end else if (bus.i_stb) begin
      if (bus.i_temp < o_min_q) o_min_d = bus.i_temp;
      if (bus.i_temp > o_max_q) o_max_d = bus.i_temp;

      case (mode_q)
        2'd1: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == {LOG2_N{1'b1}}) begin
            acc_d    = '0;
            o_temp_d = blk_avg;
            o_stb_d  = 1'b1;
          end else begin
            acc_d = blk_sum;
          end
        end
        2'd2: begin
          if (ema_state_q == EMA_EMPTY) begin
            ema_y_d     = bus.i_temp;
            o_temp_d    = bus.i_temp;
            ema_state_d = EMA_RUN;
          end else begin
            ema_y_d  = ema_next;
            o_temp_d = ema_next;
          end
          o_stb_d = 1'b1;
        end
        default: begin
          o_temp_d = bus.i_temp;
          o_stb_d  = 1'b1;
        end
      endcase

      o_valid_d = o_valid_q | o_stb_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q      <= 2'd0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ema_state_q <= EMA_EMPTY;
      ema_y_q     <= '0;
      o_temp_q    <= '0;
      o_stb_q     <= 1'b0;
      o_valid_q   <= 1'b0;
      o_min_q     <= '1;
      o_max_q     <= '0;
    end else begin
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ema_state_q <= ema_state_d;
      ema_y_q     <= ema_y_d;
      o_temp_q    <= o_temp_d;
      o_stb_q     <= o_stb_d;
      o_valid_q   <= o_valid_d;
      o_min_q     <= o_min_d;
      o_max_q     <= o_max_d;
    end
  end

  assign bus.o_temp  = o_temp_q;
  assign bus.o_stb   = o_stb_q;
  assign bus.o_valid = o_valid_q;
  assign bus.o_min   = o_min_q;
  assign bus.o_max   = o_max_q;

endmodule
`default_nettype wire

// File: tb/tb_tc_temp_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_tc_temp_filter : directed vector table plus corner-case sequences       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_tc_temp_filter;

  localparam int TEMP_W = 20;
  localparam logic [TEMP_W-1:0] ONES = '1;

  typedef struct {
    logic              clr;
    logic [1:0]        mode;
    logic              stb;
    logic [TEMP_W-1:0] temp;
    logic              e_stb;
    logic [TEMP_W-1:0] e_temp;
    logic              e_valid;
    logic [TEMP_W-1:0] e_min;
    logic [TEMP_W-1:0] e_max;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  vec_t vecs[$];

  tc_temp_filter_if #(.TEMP_W(TEMP_W)) bus ();

  tc_temp_filter #(
    .TEMP_W   (TEMP_W),
    .LOG2_N   (3),
    .EMA_SHIFT(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic clr, input logic [1:0] mode, input logic stb,
                      input logic [TEMP_W-1:0] temp);
    bus.i_clr  = clr;
    bus.i_mode = mode;
    bus.i_stb  = stb;
    bus.i_temp = temp;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic clr, input logic [1:0] mode, input logic stb,
                     input logic [TEMP_W-1:0] temp, input logic e_stb,
                     input logic [TEMP_W-1:0] e_temp, input logic e_valid,
                     input logic [TEMP_W-1:0] e_min, input logic [TEMP_W-1:0] e_max);
    vec_t v;
    v.clr = clr; v.mode = mode; v.stb = stb; v.temp = temp;
    v.e_stb = e_stb; v.e_temp = e_temp; v.e_valid = e_valid;
    v.e_min = e_min; v.e_max = e_max;
    vecs.push_back(v);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_temp"},  32'(bus.o_temp), 32'd0);
    chk({tag, "_stb"},   32'(bus.o_stb), 32'd0);
    chk({tag, "_valid"}, 32'(bus.o_valid), 32'd0);
    chk({tag, "_min"},   32'(bus.o_min), 32'(ONES));
    chk({tag, "_max"},   32'(bus.o_max), 32'd0);
  endtask

  initial begin
    int stb_cnt;
    checks = 0;
    errors = 0;

    // bypass, one-cycle strobe
    add(0, 0, 1, 20'hABCDE, 1, 20'hABCDE, 1, 20'hABCDE, 20'hABCDE);
    add(0, 0, 0, 0,         0, 20'hABCDE, 1, 20'hABCDE, 20'hABCDE);
    // block average of 100..107
    add(0, 1, 0, 0,         0, 20'hABCDE, 1, 20'hABCDE, 20'hABCDE);
    for (int i = 0; i < 8; i++)
      add(0, 1, 1, 20'(100 + i), (i == 7), (i == 7) ? 20'd103 : 20'hABCDE, 1, 20'd100, 20'hABCDE);
    add(0, 1, 0, 0,         0, 20'd103, 1, 20'd100, 20'hABCDE);
    // clear beats a coincident strobe
    add(1, 1, 1, 20'd5,     0, 20'd0, 0, ONES, 20'd0);
    // EMA 400, 0, 0
    add(0, 2, 0, 0,         0, 20'd0, 0, ONES, 20'd0);
    add(0, 2, 1, 20'd400,   1, 20'd400, 1, 20'd400, 20'd400);
    add(0, 2, 1, 20'd0,     1, 20'd300, 1, 20'd0, 20'd400);
    add(0, 2, 1, 20'd0,     1, 20'd225, 1, 20'd0, 20'd400);
    // EMA floor stall from y = 0
    add(1, 2, 0, 0,         0, 20'd0, 0, ONES, 20'd0);
    add(0, 2, 1, 20'd0,     1, 20'd0, 1, 20'd0, 20'd0);
    add(0, 2, 1, 20'd3,     1, 20'd0, 1, 20'd0, 20'd3);
    add(0, 2, 1, 20'd4,     1, 20'd1, 1, 20'd0, 20'd4);
    // min/max in bypass
    add(1, 2, 0, 0,         0, 20'd0, 0, ONES, 20'd0);
    add(0, 0, 0, 0,         0, 20'd0, 0, ONES, 20'd0);
    add(0, 0, 1, 20'd50,    1, 20'd50, 1, 20'd50, 20'd50);
    add(0, 0, 1, 20'd10,    1, 20'd10, 1, 20'd10, 20'd50);
    add(0, 0, 1, 20'd90,    1, 20'd90, 1, 20'd10, 20'd90);
    // reserved mode acts as bypass
    add(0, 3, 0, 0,         0, 20'd90, 1, 20'd10, 20'd90);
    add(0, 3, 1, 20'd7,     1, 20'd7, 1, 20'd7, 20'd90);

    bus.i_clr  = 1'b0;
    bus.i_mode = 2'd0;
    bus.i_stb  = 1'b0;
    bus.i_temp = '0;
    rst_n      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].clr, vecs[i].mode, vecs[i].stb, vecs[i].temp);
      chk($sformatf("v%0d_stb", i),   32'(bus.o_stb),   32'(vecs[i].e_stb));
      chk($sformatf("v%0d_temp", i),  32'(bus.o_temp),  32'(vecs[i].e_temp));
      chk($sformatf("v%0d_valid", i), 32'(bus.o_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_min", i),   32'(bus.o_min),   32'(vecs[i].e_min));
      chk($sformatf("v%0d_max", i),   32'(bus.o_max),   32'(vecs[i].e_max));
    end

    // reset in the middle of a block discards the partial sum
    step(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 20'd1000);
    rst_n = 1'b0;
    step(0, 1, 0, 0);
    chk_reset_state("midrst");
    rst_n = 1'b1;
    step(0, 1, 0, 0);
    stb_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 1, 20'd200);
      if (bus.o_stb) stb_cnt++;
    end
    chk("midrst_stb_count", 32'(stb_cnt), 32'd1);
    chk("midrst_avg", 32'(bus.o_temp), 32'd200);
    step(0, 1, 0, 0);
    chk("midrst_stb_drop", 32'(bus.o_stb), 32'd0);

    // mode change abandons the partial block and reseeds EMA
    step(1, 1, 0, 0);
    stb_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 1, 20'(60 + 10 * i));
      if (bus.o_stb) stb_cnt++;
    end
    chk("modechg_partial_stb", 32'(stb_cnt), 32'd0);
    step(0, 2, 1, 20'd500);
    chk("modechg_switch_stb", 32'(bus.o_stb), 32'd0);
    chk("modechg_switch_temp", 32'(bus.o_temp), 32'd0);
    chk("modechg_switch_max", 32'(bus.o_max), 32'd100);
    step(0, 2, 1, 20'd77);
    chk("modechg_seed_stb", 32'(bus.o_stb), 32'd1);
    chk("modechg_seed_temp", 32'(bus.o_temp), 32'd77);
    chk("modechg_seed_valid", 32'(bus.o_valid), 32'd1);
    chk("modechg_min", 32'(bus.o_min), 32'd60);
    chk("modechg_max", 32'(bus.o_max), 32'd100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
